// File: rtl/ntr_cmd_responder_pkg.sv
// Shared state encoding, opcode constants and sizing helper for the NTR command responder.
package ntr_cmd_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_CMD  = 2'd2,
    ST_RESP = 2'd3
  } ntr_state_t;

  localparam logic [7:0] NTR_CMD_CHIPID = 8'h90;
  localparam logic [7:0] NTR_CMD_DUMMY  = 8'h9F;
  localparam logic [7:0] NTR_CMD_HEADER = 8'h00;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ntr_cmd_responder_sync_edge.sv
// Multi-flop synchroniser for one async bus line with registered rise/fall pulses.
module ntr_cmd_responder_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], sig};
      prev  <= stage[SYNC_STAGES-1];
      rise  <= stage[SYNC_STAGES-1] & ~prev;
      fall  <= ~stage[SYNC_STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/ntr_cmd_responder.sv
// NTR cartridge-bus slave: captures a fixed-length command after dummy edges,
// then drives response bytes from a ready/valid stream on each bus clock fall.
module ntr_cmd_responder
  import ntr_cmd_responder_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                CMD_BYTES   = 8,
  parameter int                LEAD_EDGES  = 1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_BYTE   = 8'hFF,
  parameter int                CNT_W       = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ntr_clk,
  input  logic                          ntr_cs1,
  input  logic [DATA_W-1:0]             ntr_din,
  output logic [DATA_W-1:0]             ntr_dout,
  output logic                          ntr_oe,
  output logic [CMD_BYTES*DATA_W-1:0]   cmd_data,
  output logic                          cmd_valid,
  input  logic [DATA_W-1:0]             resp_data,
  input  logic                          resp_valid,
  output logic                          resp_ready,
  output logic [CNT_W-1:0]              resp_cnt,
  output logic                          underrun,
  output logic                          abort
);

  localparam int CW     = CMD_BYTES * DATA_W;
  localparam int LEAD_W = cnt_width(LEAD_EDGES);
  localparam int BYTE_W = cnt_width(CMD_BYTES);
  localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'((LEAD_EDGES > 0) ? LEAD_EDGES - 1 : 0);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(CMD_BYTES - 1);

  logic rise, fall, cs_rise, cs_fall;

  ntr_cmd_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_edge (
    .clk(clk), .rst(rst), .sig(ntr_clk), .rise(rise), .fall(fall)
  );

  ntr_cmd_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_edge (
    .clk(clk), .rst(rst), .sig(ntr_cs1), .rise(cs_rise), .fall(cs_fall)
  );

  // Data path delayed to line up with the registered edge pulses.
  logic [DATA_W-1:0] din_pipe [SYNC_STAGES+1];

  genvar gi;
  generate
    for (gi = 0; gi <= SYNC_STAGES; gi++) begin : g_din
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          din_pipe[gi] <= '0;
        else if (gi == 0)
          din_pipe[gi] <= ntr_din;
        else
          din_pipe[gi] <= din_pipe[(gi > 0) ? gi - 1 : 0];
      end
    end
  endgenerate

  ntr_state_t          state_reg, state_next;
  logic [LEAD_W-1:0]   lead_reg, lead_next;
  logic [BYTE_W-1:0]   byte_reg, byte_next;
  logic [CW-1:0]       shift_reg, shift_next, shifted;
  logic [CW-1:0]       cmd_reg, cmd_next;
  logic                cmd_valid_reg, cmd_valid_next;
  logic                abort_reg, abort_next;
  logic                oe_reg, oe_next;
  logic [DATA_W-1:0]   dout_reg, dout_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                under_reg, under_next;

  assign shifted = CW'({shift_reg, din_pipe[SYNC_STAGES]});

  always_comb begin
    state_next     = state_reg;
    lead_next      = lead_reg;
    byte_next      = byte_reg;
    shift_next     = shift_reg;
    cmd_next       = cmd_reg;
    cmd_valid_next = 1'b0;
    abort_next     = 1'b0;
    oe_next        = oe_reg;
    dout_next      = dout_reg;
    cnt_next       = cnt_reg;
    under_next     = under_reg;
    resp_ready     = 1'b0;

    // End of transfer has priority over any bus edge seen in the same cycle.
    if (cs_rise) begin
      state_next = ST_IDLE;
      oe_next    = 1'b0;
      abort_next = (state_reg == ST_LEAD) || (state_reg == ST_CMD);
    end else begin
      case (state_reg)
        ST_IDLE: if (cs_fall) begin
          state_next = (LEAD_EDGES > 0) ? ST_LEAD : ST_CMD;
          lead_next  = '0;
          byte_next  = '0;
          cnt_next   = '0;
          under_next = 1'b0;
        end
        ST_LEAD: if (rise) begin
          if (lead_reg == LEAD_LAST) state_next = ST_CMD;
          else                       lead_next  = lead_reg + 1'b1;
        end
        ST_CMD: if (rise) begin
          shift_next = shifted;
          if (byte_reg == BYTE_LAST) begin
            cmd_next       = shifted;
            cmd_valid_next = 1'b1;
            state_next     = ST_RESP;
          end else begin
            byte_next = byte_reg + 1'b1;
          end
        end
        ST_RESP: if (fall) begin
          oe_next = 1'b1;
          if (resp_valid) begin
            dout_next  = resp_data;
            resp_ready = 1'b1;
          end else begin
            dout_next  = FILL_BYTE;
            under_next = 1'b1;
          end
          if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      lead_reg      <= '0;
      byte_reg      <= '0;
      shift_reg     <= '0;
      cmd_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      abort_reg     <= 1'b0;
      oe_reg        <= 1'b0;
      dout_reg      <= FILL_BYTE;
      cnt_reg       <= '0;
      under_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lead_reg      <= lead_next;
      byte_reg      <= byte_next;
      shift_reg     <= shift_next;
      cmd_reg       <= cmd_next;
      cmd_valid_reg <= cmd_valid_next;
      abort_reg     <= abort_next;
      oe_reg        <= oe_next;
      dout_reg      <= dout_next;
      cnt_reg       <= cnt_next;
      under_reg     <= under_next;
    end
  end

  assign ntr_oe    = oe_reg & ~cs_rise;
  assign ntr_dout  = dout_reg;
  assign cmd_data  = cmd_reg;
  assign cmd_valid = cmd_valid_reg;
  assign abort     = abort_reg;
  assign resp_cnt  = cnt_reg;
  assign underrun  = under_reg;

endmodule

// File: tb/tb_ntr_cmd_responder.sv
// Directed bench for ntr_cmd_responder: command capture, response stream, underrun, abort, reset.
module tb_ntr_cmd_responder;
  import ntr_cmd_responder_pkg::*;

  localparam int H = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        ntr_clk, ntr_cs1;
  logic [7:0]  ntr_din, ntr_dout;
  logic        ntr_oe;
  logic [63:0] cmd_data;
  logic        cmd_valid;
  logic [7:0]  resp_data;
  logic        resp_valid, resp_ready;
  logic [11:0] resp_cnt;
  logic        underrun, abort;

  always #5 clk = ~clk;

  ntr_cmd_responder dut (
    .clk(clk), .rst(rst), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1), .ntr_din(ntr_din),
    .ntr_dout(ntr_dout), .ntr_oe(ntr_oe), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_cnt(resp_cnt), .underrun(underrun), .abort(abort)
  );

  // Response stream source: written by the stimulus, drained by resp_ready.
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cap_n = 0, abort_n = 0, pop_n = 0;

  assign resp_valid = (rd_ptr != wr_ptr);
  assign resp_data  = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (resp_ready && resp_valid) rd_ptr <= rd_ptr + 1;
    if (resp_ready) pop_n <= pop_n + 1;
    if (cmd_valid) cap_n <= cap_n + 1;
    if (abort) abort_n <= abort_n + 1;
  end

  int n_cmp = 0, n_err = 0;
  int exp_cnt = 0, cap_seen = 0;
  logic exp_under = 1'b0;
  logic [7:0]  model_q[$];
  logic [7:0]  exp_q[$];
  logic [63:0] cmd_exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr++;
    model_q.push_back(b);
  endtask

  task automatic model_fall();
    exp_cnt++;
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    else begin
      exp_q.push_back(8'hFF);
      exp_under = 1'b1;
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    ntr_din = d;
    #(H); ntr_clk = 1'b1;
    #(H); ntr_clk = 1'b0;
  endtask

  task automatic start_xfer();
    #20; ntr_cs1 = 1'b0;
    exp_cnt = 0; exp_under = 1'b0;
    #(H);
    chk("resp_cnt_clear", resp_cnt, 0);
    chk("underrun_clear", underrun, 0);
    pulse(8'h00);
  endtask

  task automatic send_cmd(input logic [63:0] c);
    logic [63:0] e;
    cmd_exp_q.push_back(c);
    for (int i = 0; i < 8; i++) pulse(c[63-8*i -: 8]);
    model_fall();
    for (int k = 0; k < 50 && cap_n == cap_seen; k++) @(negedge clk);
    e = cmd_exp_q.pop_front();
    chk("cmd_valid_count", cap_n, cap_seen + 1);
    chk("cmd_data", cmd_data, e);
    cap_seen = cap_n;
  endtask

  task automatic resp_bytes(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      #(H);
      e = 8'hxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("ntr_oe_resp", ntr_oe, 1);
      chk("ntr_dout", ntr_dout, e);
      ntr_clk = 1'b1;
      #(H);
      if (i < n - 1) begin
        ntr_clk = 1'b0;
        model_fall();
      end
    end
  endtask

  task automatic end_xfer();
    chk("resp_cnt", resp_cnt, exp_cnt);
    chk("underrun", underrun, exp_under);
    ntr_cs1 = 1'b1;
    #(H);
    chk("ntr_oe_idle", ntr_oe, 0);
    ntr_clk = 1'b0;
  endtask

  initial begin
    int p0, a0;
    rst = 1'b1; ntr_clk = 1'b0; ntr_cs1 = 1'b1; ntr_din = 8'h00;
    #30;
    chk("rst_oe", ntr_oe, 0);
    chk("rst_dout", ntr_dout, 8'hFF);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_resp_cnt", resp_cnt, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_abort", abort, 0);
    #10; rst = 1'b0;
    #40;

    // Chip-ID command followed by a four-byte response
    load(8'hC2); load(8'h0F); load(8'h00); load(8'h00);
    p0 = pop_n;
    start_xfer();
    send_cmd({NTR_CMD_CHIPID, 56'h0});
    resp_bytes(4);
    chk("pops_resp", pop_n - p0, 4);
    end_xfer();

    // Underrun on an empty stream, started 100 ns after the previous transfer
    p0 = pop_n;
    start_xfer();
    send_cmd({NTR_CMD_DUMMY, 56'h0});
    resp_bytes(3);
    chk("pops_underrun", pop_n - p0, 0);
    end_xfer();

    // Abort after five command bytes
    a0 = abort_n;
    start_xfer();
    for (int i = 0; i < 5; i++) pulse(8'h11 * (i + 1));
    ntr_cs1 = 1'b1;
    for (int k = 0; k < 50 && abort_n == a0; k++) @(negedge clk);
    chk("abort_count", abort_n, a0 + 1);
    chk("abort_no_cmd", cap_n, cap_seen);
    #10;
    start_xfer();
    send_cmd(64'hFF00_0000_0000_0000);
    resp_bytes(1);
    end_xfer();

    // Reset during the response phase
    load(8'hAA); load(8'hBB);
    a0 = abort_n;
    start_xfer();
    send_cmd({NTR_CMD_HEADER, 56'h0});
    resp_bytes(1);
    rst = 1'b1;
    #1;
    chk("midrst_oe", ntr_oe, 0);
    chk("midrst_dout", ntr_dout, 8'hFF);
    chk("midrst_resp_cnt", resp_cnt, 0);
    chk("midrst_cmd_data", cmd_data, 0);
    #9; ntr_cs1 = 1'b1; ntr_clk = 1'b0;
    #40; rst = 1'b0;
    #40;
    chk("midrst_no_abort", abort_n, a0);
    exp_q.delete();
    start_xfer();
    send_cmd({NTR_CMD_CHIPID, 56'h0});
    resp_bytes(1);
    end_xfer();

    #100;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
